// File: rtl/mig_wr_drain_if.sv
// FIFO read port plus MIG application write-data and command channels
// between the drain stage (master) and the FIFO/MIG side (slave).
interface mig_wr_drain_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned APP_DW = 128,
  parameter int unsigned ADDR_W = 28
);
  logic                  fifo_empty;
  logic [DW-1:0]         fifo_rdata;
  logic                  fifo_re;
  logic [ADDR_W-1:0]     app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [APP_DW-1:0]     app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [APP_DW/8-1:0]   app_wdf_mask;
  logic                  app_wdf_rdy;

  modport master (
    input  fifo_empty, fifo_rdata, app_rdy, app_wdf_rdy,
    output fifo_re, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    output fifo_empty, fifo_rdata, app_rdy, app_wdf_rdy,
    input  fifo_re, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );
endinterface

// File: rtl/mig_wr_drain.sv
// Pops APP_DW/DW FIFO words into one MIG data beat, writes it on app_wdf_*,
// then issues the matching write command at an auto-incrementing address.
module mig_wr_drain #(
  parameter int unsigned DW        = 32,
  parameter int unsigned APP_DW    = 128,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  mig_wr_drain_if.master    bus,
  output logic              busy,
  output logic [31:0]       beat_cnt
);

  localparam int unsigned RATIO = APP_DW / DW;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WDATA = 2'd2,
    CMD   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [APP_DW-1:0]   pack;
  logic [ADDR_W-1:0]   cur_addr;

  logic                fifo_re;
  logic                app_en;
  logic                wdf_wren;
  logic                cmd_acc;

  assign cmd_acc = (state == CMD) && bus.app_rdy;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = FILL;
      FILL:    if (fifo_re && (idx == IDX_LAST)) state_nxt = WDATA;
      WDATA:   if (bus.app_wdf_rdy) state_nxt = CMD;
      CMD:     if (bus.app_rdy) state_nxt = enable ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode; fifo_re additionally gated by the empty flag
  always_comb begin
    fifo_re  = 1'b0;
    app_en   = 1'b0;
    wdf_wren = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      FILL:    begin busy = 1'b1; fifo_re = !bus.fifo_empty; end
      WDATA:   begin busy = 1'b1; wdf_wren = 1'b1; end
      CMD:     begin busy = 1'b1; app_en = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Lane packing, address and beat bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx      <= '0;
      pack     <= '0;
      cur_addr <= ADDR_W'(BASE_ADDR);
      beat_cnt <= 32'd0;
    end else begin
      if (fifo_re) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        for (int unsigned l = 0; l < RATIO; l++) begin
          if (idx == IDX_W'(l)) pack[l*DW +: DW] <= bus.fifo_rdata;
        end
      end
      if (cmd_acc) begin
        cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

  assign bus.fifo_re      = fifo_re;
  assign bus.app_en       = app_en;
  assign bus.app_addr     = cur_addr;
  assign bus.app_cmd      = 3'b000;
  assign bus.app_wdf_data = pack;
  assign bus.app_wdf_wren = wdf_wren;
  assign bus.app_wdf_end  = wdf_wren;
  assign bus.app_wdf_mask = '0;

endmodule

// File: tb/tb_mig_wr_drain.sv
// Bench for mig_wr_drain: bench-owned FIFO, per-cycle scoreboard of beats and
// addresses, directed corner cases, randomized traffic, and an address-wrap instance.
module tb_mig_wr_drain;
  localparam int unsigned DW     = 32;
  localparam int unsigned APP_DW = 128;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned BASE   = 0;
  localparam int unsigned STEP   = 8;
  localparam int unsigned R      = APP_DW / DW;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic [31:0] beat_cnt;
  logic        enable2 = 1'b0;
  logic        busy2;
  logic [31:0] beat_cnt2;

  always #5 clk = ~clk;

  mig_wr_drain_if #(.DW(DW), .APP_DW(APP_DW), .ADDR_W(ADDR_W)) bus ();
  mig_wr_drain_if #(.DW(32), .APP_DW(32), .ADDR_W(6)) bus2 ();

  mig_wr_drain #(.DW(DW), .APP_DW(APP_DW), .ADDR_W(ADDR_W),
                 .BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus),
    .busy(busy), .beat_cnt(beat_cnt));

  mig_wr_drain #(.DW(32), .APP_DW(32), .ADDR_W(6),
                 .BASE_ADDR(56), .ADDR_STEP(8)) dut2 (
    .clk(clk), .rstn(rstn), .enable(enable2), .bus(bus2),
    .busy(busy2), .beat_cnt(beat_cnt2));

  int nchecks = 0;
  int nerr    = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Bench-side FIFO feeding the main instance
  logic [31:0] fq[$];
  logic        pop_pend = 1'b0;

  task automatic refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_rdata = (fq.size() == 0) ? 32'd0 : fq[0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (pop_pend && fq.size() > 0) fq.delete(0);
    #1;
    refresh();
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic wait_wren(input string nm);
    int n = 0;
    while (!bus.app_wdf_wren && n < 100) begin tick(); n++; end
    chk(nm, bus.app_wdf_wren, 1'b1);
  endtask

  task automatic wait_beats(input string nm, input logic [31:0] target);
    int n = 0;
    while (beat_cnt != target && n < 100) begin tick(); n++; end
    chk(nm, beat_cnt, target);
  endtask

  // Reference model state
  logic [31:0]        lanes [R];
  int                 pops_in_beat = 0;
  logic               data_done = 1'b0;
  logic [ADDR_W-1:0]  exp_addr = ADDR_W'(BASE);
  logic [31:0]        exp_beats = 32'd0;
  int                 total_pops = 0;
  int                 wren_run = 0, en_run = 0, wren_run_last = 0, en_run_last = 0;
  logic [127:0]       last_data = '0;
  logic [ADDR_W-1:0]  last_addr = '0;

  // Compare process: sampled mid-cycle, describes what the next edge commits
  always @(negedge clk) begin : cmp
    logic [APP_DW-1:0] e;
    logic              pop;
    if (!rstn) begin
      pops_in_beat = 0;
      data_done    = 1'b0;
      exp_addr     = ADDR_W'(BASE);
      exp_beats    = 32'd0;
      pop_pend     = 1'b0;
      wren_run     = 0;
      en_run       = 0;
    end else begin
      chk("app_cmd", bus.app_cmd, 3'b000);
      chk("wdf_mask", bus.app_wdf_mask, '0);
      chk("beat_cnt", beat_cnt, exp_beats);
      chk("wdf_end", bus.app_wdf_end, bus.app_wdf_wren);
      chk("one_valid", bus.app_wdf_wren & bus.app_en, 1'b0);
      if (bus.fifo_re) chk("re_when_empty", bus.fifo_empty, 1'b0);
      if (busy && !bus.app_wdf_wren && !bus.app_en && !bus.fifo_empty)
        chk("fill_stall", bus.fifo_re, 1'b1);
      if (!busy) chk("idle_quiet", {bus.fifo_re, bus.app_wdf_wren, bus.app_en}, 3'b000);
      if (pops_in_beat > 0 || data_done) chk("busy_midbeat", busy, 1'b1);

      pop = bus.fifo_re && !bus.fifo_empty;
      if (pop) begin
        chk("extra_pop", pops_in_beat < R, 1'b1);
        if (pops_in_beat < R) lanes[pops_in_beat] = fq[0];
        pops_in_beat++;
        total_pops++;
      end
      if (bus.app_wdf_wren) begin
        chk("pops_per_beat", pops_in_beat, R);
        for (int l = 0; l < R; l++) e[l*DW +: DW] = lanes[l];
        chk("wdf_data", bus.app_wdf_data, e);
        if (bus.app_wdf_rdy) begin data_done = 1'b1; last_data = bus.app_wdf_data; end
      end
      if (bus.app_en) begin
        chk("app_addr", bus.app_addr, exp_addr);
        chk("data_before_cmd", data_done, 1'b1);
        if (bus.app_rdy) begin
          last_addr    = bus.app_addr;
          exp_addr     = exp_addr + ADDR_W'(STEP);
          exp_beats    = exp_beats + 32'd1;
          pops_in_beat = 0;
          data_done    = 1'b0;
        end
      end
      if (bus.app_wdf_wren) wren_run++;
      else if (wren_run > 0) begin wren_run_last = wren_run; wren_run = 0; end
      if (bus.app_en) en_run++;
      else if (en_run > 0) begin en_run_last = en_run; en_run = 0; end
      pop_pend = pop;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int seen;
    logic [5:0] wa [2];
    bus.fifo_empty = 1'b1; bus.fifo_rdata = '0;
    bus.app_rdy = 1'b0;    bus.app_wdf_rdy = 1'b0;
    bus2.fifo_empty = 1'b1; bus2.fifo_rdata = '0;
    bus2.app_rdy = 1'b0;    bus2.app_wdf_rdy = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_addr", bus.app_addr, ADDR_W'(BASE));
    chk("rst_data", bus.app_wdf_data, '0);
    chk("rst_valids", {bus.fifo_re, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}, 4'b0);
    chk("rst_addr2", bus2.app_addr, 6'd56);
    rstn = 1'b1;
    tick();

    // Single beat, readies high
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    while (beat_cnt != 32'd1 && n < 50) begin tick(); n++; end
    chk("t1_cycles", n, 6);
    tick();
    chk("t1_data", last_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_addr", last_addr, 0);
    chk("t1_pops", total_pops, 4);
    chk("t1_idle", busy, 1'b0);

    // Backpressure on both channels
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_wren("t2_wren_seen");
    repeat (5) tick();
    bus.app_wdf_rdy = 1'b1;
    tick();
    bus.app_wdf_rdy = 1'b0;
    repeat (3) tick();
    bus.app_rdy = 1'b1;
    tick();
    tick();
    bus.app_wdf_rdy = 1'b1;
    chk("t2_wren_len", wren_run_last, 6);
    chk("t2_en_len", en_run_last, 4);
    chk("t2_data", last_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("t2_addr", last_addr, 8);
    chk("t2_pops", total_pops, 8);

    // Starved FIFO, enable dropped after the 2nd pop
    push(32'hB1); push(32'hB2);
    enable = 1'b1;
    tick(); tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0 || i == 9) begin
        chk("t3_re_low", bus.fifo_re, 1'b0);
        chk("t3_busy", busy, 1'b1);
      end
    end
    chk("t3_pops_mid", total_pops, 10);
    push(32'hB3); push(32'hB4);
    wait_beats("t3_done", 32'd3);
    tick();
    chk("t3_data", last_data, 128'h000000B4_000000B3_000000B2_000000B1);
    chk("t3_addr", last_addr, 16);
    chk("t3_idle", busy, 1'b0);

    // Asynchronous reset while WDATA is pending
    bus.app_wdf_rdy = 1'b0;
    push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_wren("t4_wren_seen");
    rstn = 1'b0;
    #1;
    chk("t4_rst_valids", {bus.fifo_re, bus.app_en, bus.app_wdf_wren, busy}, 4'b0);
    chk("t4_rst_data", bus.app_wdf_data, '0);
    chk("t4_rst_addr", bus.app_addr, ADDR_W'(BASE));
    chk("t4_rst_cnt", beat_cnt, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    tick(); tick();
    chk("t4_idle", busy, 1'b0);
    chk("t4_cnt", beat_cnt, 32'd0);
    chk("t4_addr", bus.app_addr, ADDR_W'(BASE));

    // Address wrap on the narrow instance (one word per beat)
    bus2.fifo_empty = 1'b0; bus2.fifo_rdata = 32'hDEADBEEF;
    bus2.app_rdy = 1'b1; bus2.app_wdf_rdy = 1'b1;
    enable2 = 1'b1;
    seen = 0; n = 0;
    wa[0] = '0; wa[1] = '0;
    while (seen < 2 && n < 40) begin
      tick(); n++;
      if (bus2.app_en) begin
        wa[seen] = bus2.app_addr;
        seen++;
        if (seen == 2) enable2 = 1'b0;
      end
    end
    tick();
    chk("t5_seen", seen, 2);
    chk("t5_addr0", wa[0], 6'd56);
    chk("t5_addr1", wa[1], 6'd0);
    chk("t5_cnt", beat_cnt2, 32'd2);
    chk("t5_idle", busy2, 1'b0);
    chk("t5_data", bus2.app_wdf_data, 32'hDEADBEEF);
    bus2.fifo_empty = 1'b1;

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 3) != 0 && fq.size() < 16) push($urandom);
      bus.app_rdy     = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
      enable          = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    for (int k = 0; k < R; k++) push($urandom);
    n = 0;
    tick();
    while (busy && n < 200) begin tick(); n++; end
    tick();
    chk("rand_drain_idle", busy, 1'b0);
    chk("rand_progress", beat_cnt >= 32'd100, 1'b1);
    chk("rand_addr", bus.app_addr, ADDR_W'(BASE) + ADDR_W'(beat_cnt * STEP));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
